alu_md_seq: RTL and testbench
=============================

Name: alu_md_seq

Overview:
- Parametrised, registered successor to the combinational MIPS ALU.
- Keeps the existing 4-bit control encoding and adds XOR, SLTU, signed-overflow and zero flags.
- Adds iterative unsigned multiply (MULTU) and divide (DIVU), which drive HI/LO-style outputs.
- Sits in the EX stage behind a valid/ready handshake; the stall logic uses o_ready to hold the pipeline during multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH), width of the iteration counter. Derived; do not override.

Ports:
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  operation request.
- o_ready  out  1  block can accept a request this cycle.
- i_op1  in  WIDTH  operand A (dividend, multiplicand).
- i_op2  in  WIDTH  operand B (divisor, multiplier).
- i_control  in  4  operation code.
- o_valid  out  1  one-cycle pulse; the result outputs are valid in this cycle.
- o_result  out  WIDTH  ALU result; product low half (MULTU); quotient (DIVU).
- o_hi  out  WIDTH  product high half (MULTU); remainder (DIVU); 0 for all other ops.
- o_zf  out  1  o_result == 0.
- o_ovf  out  1  signed overflow, ADD/SUB only; 0 for all other ops.

Behaviour:
- Control codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011.
  - SUB 0110, SLT 0111 (signed compare), SLTU 1000 (unsigned compare).
  - MULTU 1001, DIVU 1010, NOR 1100.
  - Any other code yields result 0 (single-cycle path, o_hi=0, o_ovf=0).
- Reset (async assert, sync release): state IDLE, counter 0, all datapath regs 0. Outputs: o_ready=1, o_valid=0, o_result=0, o_hi=0, o_zf=1, o_ovf=0.
- Accept happens at a rising edge when i_valid && o_ready. i_valid while o_ready=0 is ignored (request dropped; the upstream pipeline must hold it).
- States and transitions:
  - IDLE: o_ready=1. Accepting a single-cycle op registers all result outputs and pulses o_valid in the next cycle; stays IDLE (latency 1, back-to-back throughput 1/cycle). Accepting MULTU/DIVU latches operands, loads counter=WIDTH-1, goes to BUSY.
  - BUSY: o_ready=0. One shift-add (MULTU) or restoring shift-subtract (DIVU) step per cycle. At the edge where counter==0, the final result is registered, o_valid pulses and the state returns to IDLE. Latency is WIDTH+1 cycles from the accept edge to the o_valid cycle; o_ready is low for exactly WIDTH cycles.
- Holding and flags:
  - Outputs hold their last value between pulses; o_valid is high for exactly one cycle per accepted op.
  - o_zf is computed on o_result only.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - o_ovf = operands of the same sign (ADD) or opposite sign (SUB) and the result sign differs from op1.
  - SLT/SLTU return 1 or 0, zero-extended to WIDTH.
  - MULTU gives the full 2*WIDTH product split as {o_hi,o_result}.
  - DIVU by zero: quotient all ones, remainder = op1, full WIDTH+1 latency, no error flag.
- Boundaries:
  - An accept in the same cycle as the o_valid pulse of a finishing multi-cycle op is legal (o_ready=1 in that cycle).
  - Reset asserted mid-BUSY aborts the op with no o_valid pulse; all outputs take their reset values immediately.
  - Operands changing during BUSY have no effect.

Test Plan:
- Reset then idle: after release o_ready=1, o_valid=0, o_zf=1. Pulse i_rst_n low during BUSY -> o_ready=1 and o_valid=0 immediately, with no pulse afterwards.
- Back-to-back single-cycle ops:
  - ADD 7+5 -> o_result=12, o_valid one cycle later.
  - SUB 5-5 -> 0 with o_zf=1.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU with the same operands -> 0.
  - NOR 0,0 -> 0xFFFFFFFF.
  - All issued on consecutive cycles, each giving one o_valid.
- Overflow: ADD 0x7FFFFFFF+1 -> 0x80000000, o_ovf=1. SUB 0x80000000-1 -> 0x7FFFFFFF, o_ovf=1. ADD 1+1 -> o_ovf=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> o_hi=0xFFFFFFFE, o_result=0x00000001. o_valid comes exactly 33 cycles after accept; o_ready is low 32 cycles; i_valid during BUSY is ignored.
- DIVU: 100/7 -> o_result=14, o_hi=2. 5/0 -> o_result=0xFFFFFFFF, o_hi=5. A new ADD accepted in the DIVU o_valid cycle -> its result follows one cycle later.
- Parameter sweep WIDTH=8: MULTU 200*200 -> {o_hi,o_result}=0x9C40, latency 9 cycles. Random single-cycle and multi-cycle ops checked against a reference model.

Source files
------------

// File: rtl/alu_md_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_md_seq
// Purpose  : Registered MIPS-style ALU with iterative unsigned multiply/divide
//            behind a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module alu_md_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic [3:0]       i_control,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_zf,
    output logic             o_ovf
);

    localparam logic [3:0] c_OP_AND   = 4'b0000;
    localparam logic [3:0] c_OP_OR    = 4'b0001;
    localparam logic [3:0] c_OP_ADD   = 4'b0010;
    localparam logic [3:0] c_OP_XOR   = 4'b0011;
    localparam logic [3:0] c_OP_SUB   = 4'b0110;
    localparam logic [3:0] c_OP_SLT   = 4'b0111;
    localparam logic [3:0] c_OP_SLTU  = 4'b1000;
    localparam logic [3:0] c_OP_MULTU = 4'b1001;
    localparam logic [3:0] c_OP_DIVU  = 4'b1010;
    localparam logic [3:0] c_OP_NOR   = 4'b1100;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam int               c_MSB      = WIDTH - 1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_is_md;

    logic [WIDTH-1:0] w_mul_addend;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_nxt_hi;
    logic [WIDTH-1:0] w_nxt_lo;

    assign o_ready = (r_state == c_IDLE);
    assign w_sum   = i_op1 + i_op2;
    assign w_diff  = i_op1 - i_op2;
    assign w_is_md = (i_control == c_OP_MULTU) || (i_control == c_OP_DIVU);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (i_control)
            c_OP_AND:  w_res = i_op1 & i_op2;
            c_OP_OR:   w_res = i_op1 | i_op2;
            c_OP_XOR:  w_res = i_op1 ^ i_op2;
            c_OP_NOR:  w_res = ~(i_op1 | i_op2);
            c_OP_ADD: begin
                w_res = w_sum;
                w_ovf = (i_op1[c_MSB] == i_op2[c_MSB]) && (w_sum[c_MSB] != i_op1[c_MSB]);
            end
            c_OP_SUB: begin
                w_res = w_diff;
                w_ovf = (i_op1[c_MSB] != i_op2[c_MSB]) && (w_diff[c_MSB] != i_op1[c_MSB]);
            end
            c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
            c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (i_op1 < i_op2)};
            default:   w_res = '0;
        endcase
    end

    // Multiply: {hi,lo} shifts right, multiplier bits consumed from lo[0].
    // Divide: {rem,dividend} shifts left, quotient bits enter at lo[0];
    // a zero divisor naturally yields all-ones quotient and remainder = op1.
    assign w_mul_addend = r_lo[0] ? r_b : '0;
    assign w_mul_sum    = {1'b0, r_hi} + {1'b0, w_mul_addend};
    assign w_div_shift  = {r_hi, r_lo[c_MSB]};
    assign w_div_ge     = (w_div_shift >= {1'b0, r_b});
    assign w_div_diff   = w_div_shift[WIDTH-1:0] - r_b;

    assign w_nxt_hi = r_is_div ? (w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0])
                               : w_mul_sum[WIDTH:1];
    assign w_nxt_lo = r_is_div ? {r_lo[WIDTH-2:0], w_div_ge}
                               : {w_mul_sum[0], r_lo[WIDTH-1:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_hi     <= '0;
            o_zf     <= 1'b1;
            o_ovf    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (i_valid) begin
                        if (w_is_md) begin
                            r_state  <= c_BUSY;
                            r_cnt    <= c_CNT_LAST;
                            r_is_div <= (i_control == c_OP_DIVU);
                            r_hi     <= '0;
                            r_lo     <= (i_control == c_OP_DIVU) ? i_op1 : i_op2;
                            r_b      <= (i_control == c_OP_DIVU) ? i_op2 : i_op1;
                        end else begin
                            o_result <= w_res;
                            o_hi     <= '0;
                            o_zf     <= (w_res == '0);
                            o_ovf    <= w_ovf;
                            o_valid  <= 1'b1;
                        end
                    end
                end
                c_BUSY: begin
                    r_hi <= w_nxt_hi;
                    r_lo <= w_nxt_lo;
                    if (r_cnt == '0) begin
                        r_state  <= c_IDLE;
                        o_result <= w_nxt_lo;
                        o_hi     <= w_nxt_hi;
                        o_zf     <= (w_nxt_lo == '0);
                        o_ovf    <= 1'b0;
                        o_valid  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_md_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_md_seq
// Purpose  : Randomised self-checking bench for alu_md_seq at WIDTH=32 and 8.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_md_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid;
    logic [3:0]  ctl;
    logic [31:0] op1, op2;
    int          w;
    int          n_vec = 0;
    int          n_err = 0;

    logic        v32, v8;
    assign v32 = valid && (w == 32);
    assign v8  = valid && (w == 8);

    logic        rdy32, val32, zf32, ovf32;
    logic [31:0] res32, hi32;
    logic        rdy8, val8, zf8, ovf8;
    logic [7:0]  res8, hi8;

    alu_md_seq #(.WIDTH(32)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v32), .o_ready(rdy32),
        .i_op1(op1), .i_op2(op2), .i_control(ctl), .o_valid(val32),
        .o_result(res32), .o_hi(hi32), .o_zf(zf32), .o_ovf(ovf32)
    );

    alu_md_seq #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(rdy8),
        .i_op1(op1[7:0]), .i_op2(op2[7:0]), .i_control(ctl), .o_valid(val8),
        .o_result(res8), .o_hi(hi8), .o_zf(zf8), .o_ovf(ovf8)
    );

    logic [63:0] obs_res, obs_hi;
    logic        obs_rdy, obs_val, obs_zf, obs_ovf;

    always_comb begin
        obs_res = {32'd0, res32};
        obs_hi  = {32'd0, hi32};
        obs_rdy = rdy32;
        obs_val = val32;
        obs_zf  = zf32;
        obs_ovf = ovf32;
        if (w == 8) begin
            obs_res = {56'd0, res8};
            obs_hi  = {56'd0, hi8};
            obs_rdy = rdy8;
            obs_val = val8;
            obs_zf  = zf8;
            obs_ovf = ovf8;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wmask();
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference: plain integer arithmetic on unbounded (64-bit) values.
    function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] res, output logic [63:0] hi,
                                  output logic zf, output logic ovf);
        logic [63:0] m, p;
        longint      sa, sb, s, lim;
        m   = wmask();
        lim = longint'(64'd1 << (w - 1));
        sa  = longint'(a);
        sb  = longint'(b);
        if (a >= (64'd1 << (w - 1))) sa = sa - longint'(64'd1 << w);
        if (b >= (64'd1 << (w - 1))) sb = sb - longint'(64'd1 << w);
        res = 64'd0;
        hi  = 64'd0;
        ovf = 1'b0;
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0011: res = a ^ b;
            4'b1100: res = ~(a | b) & m;
            4'b0010: begin s = sa + sb; res = (a + b) & m; ovf = (s >= lim) || (s < -lim); end
            4'b0110: begin s = sa - sb; res = (a - b) & m; ovf = (s >= lim) || (s < -lim); end
            4'b0111: res = (sa < sb) ? 64'd1 : 64'd0;
            4'b1000: res = (a < b) ? 64'd1 : 64'd0;
            4'b1001: begin p = a * b; res = p & m; hi = p >> w; end
            4'b1010: begin
                if (b == 64'd0) begin res = m; hi = a; end
                else begin res = a / b; hi = a % b; end
            end
            default: res = 64'd0;
        endcase
        zf = (res == 64'd0);
    endfunction

    task automatic expect_out(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] er, eh;
        logic        ez, eo;
        model(op, a, b, er, eh, ez, eo);
        check({tag, ".valid"}, {63'd0, obs_val}, 64'd1);
        check({tag, ".ready"}, {63'd0, obs_rdy}, 64'd1);
        check({tag, ".result"}, obs_res, er);
        check({tag, ".hi"}, obs_hi, eh);
        check({tag, ".zf"}, {63'd0, obs_zf}, {63'd0, ez});
        check({tag, ".ovf"}, {63'd0, obs_ovf}, {63'd0, eo});
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        valid = 1'b1;
        ctl   = op;
        op1   = a[31:0];
        op2   = b[31:0];
        @(posedge clk); #1;
        expect_out(tag, op, a & wmask(), b & wmask());
    endtask

    task automatic idle_chk();
        valid = 1'b0;
        @(posedge clk); #1;
        check("idle.valid", {63'd0, obs_val}, 64'd0);
        check("idle.ready", {63'd0, obs_rdy}, 64'd1);
    endtask

    // Requests issued while busy carry unrelated operands and must be dropped.
    task automatic multi(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input bit follow);
        int n, low;
        valid = 1'b1;
        ctl   = op;
        op1   = a[31:0];
        op2   = b[31:0];
        @(posedge clk); #1;
        n   = 0;
        low = 0;
        while (!obs_val && n < w + 8) begin
            if (!obs_rdy) low++;
            valid = 1'b1;
            ctl   = 4'b0010;
            op1   = $urandom;
            op2   = $urandom;
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, 64'(n + 1), 64'(w + 1));
        check({tag, ".ready_low"}, 64'(low), 64'(w));
        expect_out(tag, op, a & wmask(), b & wmask());
        if (follow) single({tag, ".follow_add"}, 4'b0010, 64'($urandom), 64'($urandom));
        idle_chk();
    endtask

    task automatic do_reset();
        valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst.ready", {63'd0, obs_rdy}, 64'd1);
        check("rst.valid", {63'd0, obs_val}, 64'd0);
        check("rst.zf", {63'd0, obs_zf}, 64'd1);
        check("rst.result", obs_res, 64'd0);
        check("rst.hi", obs_hi, 64'd0);
        check("rst.ovf", {63'd0, obs_ovf}, 64'd0);
    endtask

    task automatic reset_mid_busy();
        int pulses;
        valid = 1'b1;
        ctl   = 4'b1001;
        op1   = $urandom;
        op2   = $urandom;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort.ready", {63'd0, obs_rdy}, 64'd1);
        check("abort.valid", {63'd0, obs_val}, 64'd0);
        check("abort.result", obs_res, 64'd0);
        check("abort.hi", obs_hi, 64'd0);
        check("abort.zf", {63'd0, obs_zf}, 64'd1);
        #2 rst_n = 1'b1;
        pulses = 0;
        repeat (w + 4) begin
            @(posedge clk); #1;
            if (obs_val) pulses++;
        end
        check("abort.no_pulse", 64'(pulses), 64'd0);
    endtask

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return wmask();
            2: return 64'd1 << (w - 1);
            3: return 64'($urandom_range(0, 9));
            default: return 64'($urandom) & wmask();
        endcase
    endfunction

    task automatic random_ops(input int count);
        logic [3:0]  op;
        logic [63:0] a, b;
        for (int i = 0; i < count; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(9, 10));
            a = rand_val();
            b = rand_val();
            if (op == 4'b1001 || op == 4'b1010) begin
                multi("rnd_md", op, a, b, bit'($urandom_range(0, 1)));
            end else begin
                single("rnd", op, a, b);
                if ($urandom_range(0, 3) == 0) idle_chk();
            end
        end
        idle_chk();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        w     = 32;
        valid = 1'b0;
        ctl   = 4'b0000;
        op1   = '0;
        op2   = '0;
        rst_n = 1'b0;
        do_reset();

        // back-to-back single-cycle ops, one result per cycle
        single("add",      4'b0010, 64'd7, 64'd5);
        single("sub_zero", 4'b0110, 64'd5, 64'd5);
        single("slt",      4'b0111, 64'hFFFF_FFFF, 64'd1);
        single("sltu",     4'b1000, 64'hFFFF_FFFF, 64'd1);
        single("nor",      4'b1100, 64'd0, 64'd0);
        single("add_ovf",  4'b0010, 64'h7FFF_FFFF, 64'd1);
        single("sub_ovf",  4'b0110, 64'h8000_0000, 64'd1);
        single("add_novf", 4'b0010, 64'd1, 64'd1);
        single("xor",      4'b0011, 64'hA5A5_0F0F, 64'h0FF0_FFFF);
        single("bad_op",   4'b1111, 64'h1234, 64'h5678);
        idle_chk();

        multi("multu_max", 4'b1001, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
        multi("divu",      4'b1010, 64'd100, 64'd7, 1'b0);
        multi("divu_zero", 4'b1010, 64'd5, 64'd0, 1'b1);

        reset_mid_busy();
        random_ops(120);

        w = 8;
        do_reset();
        multi("multu8", 4'b1001, 64'd200, 64'd200, 1'b0);
        multi("divu8",  4'b1010, 64'd250, 64'd9, 1'b1);
        random_ops(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
